// File: rtl/bimodal_btb_bp.sv
`default_nettype none
// ============================================================================
// bimodal_btb_bp : direct-mapped BTB with 2-bit bimodal counters, EX-stage
//                  update, mispredict detect and redirect.
//                  Optional macro BP_PERF_CNT_EN adds perf_ctl/perf_mispred.
// Revision       : 1.0
// ============================================================================
module bimodal_btb_bp #(
  parameter int         IDX_BITS = 6,
  parameter int         TAG_BITS = 8,
  parameter logic [1:0] CNT_INIT = 2'b10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_is_br,
  input  logic        ex_is_jmp,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc
`ifdef BP_PERF_CNT_EN
  ,
  output logic [31:0] perf_ctl,
  output logic [31:0] perf_mispred
`endif
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic [ENTRIES-1:0]  jmp_q, jmp_d;
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [TAG_BITS-1:0] tag_d    [ENTRIES];
  logic [1:0]          cnt_q    [ENTRIES];
  logic [1:0]          cnt_d    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [31:0]         target_d [ENTRIES];

  logic [IDX_BITS-1:0] if_idx, ex_idx;
  logic [TAG_BITS-1:0] if_tag, ex_tag;
  logic                ex_ctl, ex_hit, upd;

  assign if_idx = if_pc[IDX_BITS+1:2];
  assign if_tag = if_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign ex_idx = ex_pc[IDX_BITS+1:2];
  assign ex_tag = ex_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];

  // Lookup reads only registered state, so a same-cycle update is not bypassed.
  assign pred_hit    = if_valid & valid_q[if_idx] & (tag_q[if_idx] == if_tag);
  assign pred_taken  = pred_hit & (jmp_q[if_idx] | cnt_q[if_idx][1]);
  assign pred_target = pred_taken ? target_q[if_idx] : if_pc + 32'd4;

  assign ex_ctl = ex_is_br | ex_is_jmp;
  assign upd    = ex_valid & ex_ctl & rst_n;
  assign ex_hit = valid_q[ex_idx] & (tag_q[ex_idx] == ex_tag);

  assign mispredict  = ex_valid & ex_ctl &
                       ((ex_pred_taken != ex_taken) |
                        (ex_taken & ex_pred_taken & (ex_pred_target != ex_target)));
  assign redirect_pc = ex_taken ? ex_target : ex_pc + 32'd4;

  always_comb begin
    valid_d  = valid_q;
    jmp_d    = jmp_q;
    tag_d    = tag_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    if (upd) begin
      if (ex_hit) begin
        // A simultaneous br+jmp flag is resolved as a jump.
        if (ex_is_jmp) begin
          jmp_d[ex_idx]    = 1'b1;
          target_d[ex_idx] = ex_target;
        end else if (ex_taken) begin
          if (cnt_q[ex_idx] != 2'b11) cnt_d[ex_idx] = cnt_q[ex_idx] + 2'd1;
          target_d[ex_idx] = ex_target;
        end else if (cnt_q[ex_idx] != 2'b00) begin
          cnt_d[ex_idx] = cnt_q[ex_idx] - 2'd1;
        end
      end else if (ex_taken | ex_is_jmp) begin
        valid_d[ex_idx]  = 1'b1;
        tag_d[ex_idx]    = ex_tag;
        target_d[ex_idx] = ex_target;
        jmp_d[ex_idx]    = ex_is_jmp;
        cnt_d[ex_idx]    = ex_is_jmp ? 2'b11 : CNT_INIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      jmp_q   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        cnt_q[i]    <= CNT_INIT;
        target_q[i] <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      jmp_q    <= jmp_d;
      tag_q    <= tag_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
    end
  end

`ifdef BP_PERF_CNT_EN
  logic [31:0] perf_ctl_q, perf_ctl_d;
  logic [31:0] perf_mispred_q, perf_mispred_d;

  always_comb begin
    perf_ctl_d     = perf_ctl_q + {31'd0, upd};
    perf_mispred_d = perf_mispred_q + {31'd0, upd & mispredict};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_ctl_q     <= '0;
      perf_mispred_q <= '0;
    end else begin
      perf_ctl_q     <= perf_ctl_d;
      perf_mispred_q <= perf_mispred_d;
    end
  end

  assign perf_ctl     = perf_ctl_q;
  assign perf_mispred = perf_mispred_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bimodal_btb_bp.sv
`default_nettype none
// ============================================================================
// tb_bimodal_btb_bp : self-checking bench for bimodal_btb_bp (directed
//                     scenarios plus randomized traffic against a table model).
// Revision          : 1.0
// ============================================================================
module tb_bimodal_btb_bp;

  localparam int IDX_BITS = 6;
  localparam int TAG_BITS = 8;
  localparam int ENTRIES  = 1 << IDX_BITS;

  logic        clk = 1'b0;
  logic        rst_n, if_valid, ex_valid, ex_is_br, ex_is_jmp, ex_taken, ex_pred_taken;
  logic [31:0] if_pc, ex_pc, ex_target, ex_pred_target;
  logic        pred_hit, pred_taken, mispredict;
  logic [31:0] pred_target, redirect_pc;
`ifdef BP_PERF_CNT_EN
  logic [31:0] perf_ctl, perf_mispred;
`endif

  int checks = 0;
  int errors = 0;

  // Reference table: plain integers, counter kept as 0..3 with min/max saturation.
  bit          m_valid  [ENTRIES];
  int          m_tag    [ENTRIES];
  bit          m_jmp    [ENTRIES];
  int          m_cnt    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  logic [31:0] m_ctl, m_mis;

  always #5 clk = ~clk;

  bimodal_btb_bp #(.IDX_BITS(IDX_BITS), .TAG_BITS(TAG_BITS), .CNT_INIT(2'b10)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_pc(if_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_br(ex_is_br), .ex_is_jmp(ex_is_jmp),
    .ex_taken(ex_taken), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .mispredict(mispredict), .redirect_pc(redirect_pc)
`ifdef BP_PERF_CNT_EN
    , .perf_ctl(perf_ctl), .perf_mispred(perf_mispred)
`endif
  );

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 32'd4) % ENTRIES);
  endfunction

  function automatic int tag_of(input logic [31:0] pc);
    return int'((pc / (32'd4 * ENTRIES)) % (1 << TAG_BITS));
  endfunction

  function automatic void model_lookup(input logic v, input logic [31:0] pc,
                                       output logic h, output logic t, output logic [31:0] tg);
    int i;
    i  = idx_of(pc);
    h  = v && m_valid[i] && (m_tag[i] == tag_of(pc));
    t  = h && (m_jmp[i] || m_cnt[i] >= 2);
    tg = t ? m_target[i] : pc + 32'd4;
  endfunction

  function automatic logic exp_mispredict();
    if (!(ex_valid && (ex_is_br || ex_is_jmp))) return 1'b0;
    if (ex_pred_taken != ex_taken) return 1'b1;
    return ex_taken && (ex_pred_target != ex_target);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_jmp[i] = 0; m_cnt[i] = 2; m_target[i] = 32'd0;
    end
    m_ctl = 32'd0;
    m_mis = 32'd0;
  endfunction

  function automatic void model_update();
    int  i;
    bit  hit;
    i   = idx_of(ex_pc);
    hit = m_valid[i] && (m_tag[i] == tag_of(ex_pc));
    if (ex_is_jmp) begin
      if (hit) begin
        m_jmp[i] = 1; m_target[i] = ex_target;
      end else begin
        m_valid[i] = 1; m_tag[i] = tag_of(ex_pc); m_jmp[i] = 1; m_cnt[i] = 3; m_target[i] = ex_target;
      end
    end else if (hit) begin
      if (ex_taken) begin
        m_cnt[i] = (m_cnt[i] + 1 > 3) ? 3 : m_cnt[i] + 1;
        m_target[i] = ex_target;
      end else begin
        m_cnt[i] = (m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1;
      end
    end else if (ex_taken) begin
      m_valid[i] = 1; m_tag[i] = tag_of(ex_pc); m_jmp[i] = 0; m_cnt[i] = 2; m_target[i] = ex_target;
    end
  endfunction

  // Advances one clock, mirroring the state change the DUT makes at that edge.
  task automatic tick();
    if (!rst_n) model_reset();
    else if (ex_valid && (ex_is_br || ex_is_jmp)) begin
      m_ctl = m_ctl + 32'd1;
      if (exp_mispredict()) m_mis = m_mis + 32'd1;
      model_update();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [31:0] pc, input logic br, input logic jmp,
                        input logic tk, input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    ex_valid = v; ex_pc = pc; ex_is_br = br; ex_is_jmp = jmp;
    ex_taken = tk; ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
  endtask

  task automatic clear_ex();
    set_ex(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; if_valid = 1'b1; if_pc = 32'h100;
    set_ex(1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h200, 1'b0, 32'd0);
    #1;
    checks++;
    if (mispredict !== 1'b1) begin errors++; $display("FAIL rst_mispredict got=%b exp=1", mispredict); end
    tick();
    rst_n = 1'b1; clear_ex(); #1;
    checks++;
    if (pred_hit !== 1'b0 || pred_taken !== 1'b0 || pred_target !== 32'h104) begin
      errors++; $display("FAIL rst_lookup got=%b/%b/%h exp=0/0/00000104", pred_hit, pred_taken, pred_target);
    end
    tick();
    checks++;
    if (pred_hit !== 1'b0) begin errors++; $display("FAIL rst_drop_update got=%b exp=0", pred_hit); end
  endtask

  task automatic test_branch();
    logic seq  [7];
    logic etk  [7];
    logic ptk;
    seq = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    etk = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    if_pc = 32'h100;
    set_ex(1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h200, 1'b0, 32'd0);
    #1;
    checks++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h200) begin
      errors++; $display("FAIL br_alloc_mp got=%b/%h exp=1/00000200", mispredict, redirect_pc);
    end
    tick(); clear_ex(); #1;
    checks++;
    if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 32'h200) begin
      errors++; $display("FAIL br_alloc_lookup got=%b/%b/%h exp=1/1/00000200", pred_hit, pred_taken, pred_target);
    end
    ptk = 1'b1;
    for (int k = 0; k < 7; k++) begin
      set_ex(1'b1, 32'h100, 1'b1, 1'b0, seq[k], 32'h200, ptk, ptk ? 32'h200 : 32'h104);
      #1;
      checks++;
      if (mispredict !== (ptk != seq[k]) || redirect_pc !== (seq[k] ? 32'h200 : 32'h104)) begin
        errors++; $display("FAIL br_step%0d_mp got=%b/%h exp=%b", k, mispredict, redirect_pc, ptk != seq[k]);
      end
      tick(); clear_ex(); #1;
      checks++;
      if (pred_hit !== 1'b1 || pred_taken !== etk[k] || pred_target !== (etk[k] ? 32'h200 : 32'h104)) begin
        errors++; $display("FAIL br_step%0d_lookup got=%b/%b/%h exp=1/%b", k, pred_hit, pred_taken, pred_target, etk[k]);
      end
      ptk = etk[k];
    end
  endtask

  task automatic test_alias();
    logic [31:0] pc2, pc3;
    pc2 = 32'h100 + (32'd4 << IDX_BITS);
    pc3 = 32'h100 + (32'd8 << IDX_BITS);
    set_ex(1'b1, pc2, 1'b1, 1'b0, 1'b1, 32'h600, 1'b0, 32'd0);
    tick(); clear_ex();
    if_pc = 32'h100; #1;
    checks++;
    if (pred_hit !== 1'b0) begin errors++; $display("FAIL alias_evict got=%b exp=0", pred_hit); end
    if_pc = pc2; #1;
    checks++;
    if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 32'h600) begin
      errors++; $display("FAIL alias_new got=%b/%b/%h exp=1/1/00000600", pred_hit, pred_taken, pred_target);
    end
    set_ex(1'b1, pc3, 1'b1, 1'b0, 1'b0, 32'h700, 1'b0, 32'd0); #1;
    checks++;
    if (mispredict !== 1'b0 || redirect_pc !== pc3 + 32'd4) begin
      errors++; $display("FAIL alias_nt_mp got=%b/%h exp=0/%h", mispredict, redirect_pc, pc3 + 32'd4);
    end
    tick(); clear_ex(); #1;
    checks++;
    if (pred_hit !== 1'b1 || pred_target !== 32'h600) begin
      errors++; $display("FAIL alias_no_evict got=%b/%h exp=1/00000600", pred_hit, pred_target);
    end
    if_pc = pc3; #1;
    checks++;
    if (pred_hit !== 1'b0) begin errors++; $display("FAIL alias_nt_alloc got=%b exp=0", pred_hit); end
  endtask

  task automatic test_jump();
    set_ex(1'b1, 32'h300, 1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 32'd0); #1;
    checks++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h40) begin
      errors++; $display("FAIL jal_mp got=%b/%h exp=1/00000040", mispredict, redirect_pc);
    end
    tick(); clear_ex(); if_pc = 32'h300; #1;
    checks++;
    if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 32'h40) begin
      errors++; $display("FAIL jal_lookup got=%b/%b/%h exp=1/1/00000040", pred_hit, pred_taken, pred_target);
    end
    set_ex(1'b1, 32'h300, 1'b0, 1'b1, 1'b1, 32'h80, 1'b1, 32'h40); #1;
    checks++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h80) begin
      errors++; $display("FAIL jalr_mp got=%b/%h exp=1/00000080", mispredict, redirect_pc);
    end
    tick();
    set_ex(1'b1, 32'h300, 1'b1, 1'b1, 1'b1, 32'h80, 1'b1, 32'h80); #1;
    checks++;
    if (pred_target !== 32'h80 || mispredict !== 1'b0) begin
      errors++; $display("FAIL jalr_retarget got=%h/%b exp=00000080/0", pred_target, mispredict);
    end
    tick(); clear_ex();
  endtask

  task automatic test_collision();
    if_pc = 32'h104;
    set_ex(1'b1, 32'h104, 1'b1, 1'b0, 1'b1, 32'h1000, 1'b0, 32'd0); #1;
    checks++;
    if (pred_hit !== 1'b0 || pred_target !== 32'h108) begin
      errors++; $display("FAIL coll_alloc_old got=%b/%h exp=0/00000108", pred_hit, pred_target);
    end
    tick(); clear_ex(); #1;
    checks++;
    if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 32'h1000) begin
      errors++; $display("FAIL coll_alloc_new got=%b/%b/%h exp=1/1/00001000", pred_hit, pred_taken, pred_target);
    end
    set_ex(1'b1, 32'h104, 1'b1, 1'b0, 1'b0, 32'h1000, 1'b1, 32'h1000); #1;
    checks++;
    if (pred_taken !== 1'b1) begin errors++; $display("FAIL coll_cnt_old got=%b exp=1", pred_taken); end
    tick(); clear_ex(); #1;
    checks++;
    if (pred_hit !== 1'b1 || pred_taken !== 1'b0 || pred_target !== 32'h108) begin
      errors++; $display("FAIL coll_cnt_new got=%b/%b/%h exp=1/0/00000108", pred_hit, pred_taken, pred_target);
    end
  endtask

  task automatic test_wrap_and_gate();
    if_valid = 1'b0; if_pc = 32'h100 + (32'd4 << IDX_BITS); #1;
    checks++;
    if (pred_hit !== 1'b0 || pred_taken !== 1'b0 || pred_target !== if_pc + 32'd4) begin
      errors++; $display("FAIL if_valid_gate got=%b/%b/%h exp=0/0/%h", pred_hit, pred_taken, pred_target, if_pc + 32'd4);
    end
    if_valid = 1'b1; if_pc = 32'hFFFF_FFFC;
    set_ex(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 32'h10); #1;
    checks++;
    if (pred_target !== 32'd0 || mispredict !== 1'b1 || redirect_pc !== 32'd0) begin
      errors++; $display("FAIL wrap got=%h/%b/%h exp=00000000/1/00000000", pred_target, mispredict, redirect_pc);
    end
    tick(); clear_ex();
  endtask

  task automatic test_reset_midstream();
    logic [31:0] pcs [4];
    pcs = '{32'h104, 32'h108, 32'h300, 32'h100 + (32'd4 << IDX_BITS)};
    rst_n = 1'b0;
    set_ex(1'b1, 32'h108, 1'b1, 1'b0, 1'b1, 32'h2000, 1'b0, 32'd0);
    tick();
    rst_n = 1'b1; clear_ex();
    for (int k = 0; k < 4; k++) begin
      if_pc = pcs[k]; #1;
      checks++;
      if (pred_hit !== 1'b0 || pred_taken !== 1'b0) begin
        errors++; $display("FAIL midrst_empty%0d got=%b/%b exp=0/0", k, pred_hit, pred_taken);
      end
    end
`ifdef BP_PERF_CNT_EN
    checks++;
    if (perf_ctl !== 32'd0 || perf_mispred !== 32'd0) begin
      errors++; $display("FAIL perf_reset got=%0d/%0d exp=0/0", perf_ctl, perf_mispred);
    end
`endif
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] hi;
    hi = $urandom;
    return (hi & 32'hFFFF_0000) | (32'($urandom_range(0, 3)) << (IDX_BITS + 2))
         | (32'($urandom_range(0, 7)) << 2);
  endfunction

  task automatic test_random();
    logic        eh, et;
    logic [31:0] etg;
    int          kind;
    for (int c = 0; c < 600; c++) begin
      kind = $urandom_range(0, 4);
      ex_valid  = ($urandom_range(0, 7) != 0);
      ex_pc     = rand_pc();
      ex_is_br  = (kind == 1 || kind == 2 || kind == 4);
      ex_is_jmp = (kind == 3 || kind == 4);
      ex_taken  = ex_is_jmp ? 1'b1 : 1'($urandom_range(0, 1));
      ex_target = $urandom & 32'hFFFF_FFFC;
      model_lookup(1'b1, ex_pc, eh, et, etg);
      if ($urandom_range(0, 3) != 0) begin
        ex_pred_taken = et; ex_pred_target = etg;
      end else begin
        ex_pred_taken = 1'($urandom_range(0, 1)); ex_pred_target = $urandom & 32'hFFFF_FFFC;
      end
      if_valid = ($urandom_range(0, 7) != 0);
      if_pc    = ($urandom_range(0, 4) == 0) ? ex_pc : rand_pc();
      #1;
      model_lookup(if_valid, if_pc, eh, et, etg);
      checks++;
      if (pred_hit !== eh) begin errors++; $display("FAIL rand_hit c=%0d got=%b exp=%b", c, pred_hit, eh); end
      checks++;
      if (pred_taken !== et) begin errors++; $display("FAIL rand_taken c=%0d got=%b exp=%b", c, pred_taken, et); end
      checks++;
      if (pred_target !== etg) begin errors++; $display("FAIL rand_target c=%0d got=%h exp=%h", c, pred_target, etg); end
      checks++;
      if (mispredict !== exp_mispredict()) begin
        errors++; $display("FAIL rand_mp c=%0d got=%b exp=%b", c, mispredict, exp_mispredict());
      end
      checks++;
      if (redirect_pc !== (ex_taken ? ex_target : ex_pc + 32'd4)) begin
        errors++; $display("FAIL rand_redirect c=%0d got=%h exp=%h", c, redirect_pc, ex_taken ? ex_target : ex_pc + 32'd4);
      end
      tick();
    end
    clear_ex();
    #1;
`ifdef BP_PERF_CNT_EN
    checks++;
    if (perf_ctl !== m_ctl || perf_mispred !== m_mis) begin
      errors++; $display("FAIL perf_totals got=%0d/%0d exp=%0d/%0d", perf_ctl, perf_mispred, m_ctl, m_mis);
    end
`endif
  endtask

  initial begin
    rst_n = 1'b0; if_valid = 1'b0; if_pc = 32'd0;
    clear_ex();
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_branch();
    test_alias();
    test_jump();
    test_collision();
    test_wrap_and_gate();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
